register: RTL and testbench

General-purpose integer register file for the RV32I processor datapath. Holds 32 architectural registers of 32 bits, with x0 hardwired to zero. It provides two read ports, feeding rs1 and rs2 into the ALU/execute stage, and one write port, fed from writeback. A single mode bit selects per cycle whether the block performs a write or a read.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/reg_read_port.sv | 22 ++
 rtl/register.sv | 65 ++++++
 tb/tb_register.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants.
// Register-file geometry and the r_or_w mode encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic RD_MODE = 1'b1;
    localparam logic WR_MODE = 1'b0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the integer register file.
// x0 is forced to zero here regardless of array contents.
module reg_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NREGS      = 2 ** ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [NREGS-1:0][DATA_WIDTH-1:0]  regs,
    output logic [DATA_WIDTH-1:0]             data
);

    always_comb begin
        data = '0;
        if (addr != '0) begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/register.sv
// RV32I integer register file: 32 x 32, two registered read ports,
// one write port, and a per-cycle read/write mode select.
module register
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] register_read_addr_1,
    input  logic [ADDR_WIDTH-1:0] register_read_addr_2,
    input  logic [ADDR_WIDTH-1:0] register_write_addr,
    input  logic                  r_or_w,
    input  logic [DATA_WIDTH-1:0] write_reg_val,
    output logic [DATA_WIDTH-1:0] read_reg_value_1,
    output logic [DATA_WIDTH-1:0] read_reg_value_2
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [NREGS-1:0][DATA_WIDTH-1:0] regs;
    logic [DATA_WIDTH-1:0]            rd_data_1;
    logic [DATA_WIDTH-1:0]            rd_data_2;

    // x0 is never written, so its storage stays at its reset value of 0
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (r_or_w == WR_MODE && register_write_addr != '0) begin
            regs[register_write_addr] <= write_reg_val;
        end
    end

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREGS      (NREGS)
    ) u_port_1 (
        .addr (register_read_addr_1),
        .regs (regs),
        .data (rd_data_1)
    );

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NREGS      (NREGS)
    ) u_port_2 (
        .addr (register_read_addr_2),
        .regs (regs),
        .data (rd_data_2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            read_reg_value_1 <= '0;
            read_reg_value_2 <= '0;
        end else if (r_or_w == RD_MODE) begin
            read_reg_value_1 <= rd_data_1;
            read_reg_value_2 <= rd_data_2;
        end
    end

endmodule

// File: tb/tb_register.sv
// Directed testbench for the register file.
module tb_register;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic        r_or_w;
    logic [31:0] wval;
    logic [31:0] rv1;
    logic [31:0] rv2;

    int passed;
    int total;

    register dut (
        .clk                  (clk),
        .reset                (reset),
        .register_read_addr_1 (ra1),
        .register_read_addr_2 (ra2),
        .register_write_addr  (wa),
        .r_or_w               (r_or_w),
        .write_reg_val        (wval),
        .read_reg_value_1     (rv1),
        .read_reg_value_2     (rv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] v);
        reset  = 1'b0;
        r_or_w = 1'b0;
        wa     = a;
        wval   = v;
        tick();
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        reset  = 1'b0;
        r_or_w = 1'b1;
        ra1    = a1;
        ra2    = a2;
        tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        r_or_w = 1'b1;
        ra1    = 5'd0;
        ra2    = 5'd0;
        wa     = 5'd0;
        wval   = 32'h0;
        tick();
        total++;
        if ({rv1, rv2} !== 64'h0)
            $display("FAIL reset_out got %h/%h expected 0/0", rv1, rv2);
        else
            passed++;
        do_read(5'd4, 5'd20);
        total++;
        if (rv1 !== 32'h0)
            $display("FAIL reset_rd1 got %h expected 0", rv1);
        else
            passed++;
        total++;
        if (rv2 !== 32'h0)
            $display("FAIL reset_rd2 got %h expected 0", rv2);
        else
            passed++;
    endtask

    task automatic test_write_read();
        do_write(5'd4, 32'h12);
        do_write(5'd20, 32'h2);
        do_write(5'd5, 32'h0A);
        do_read(5'd5, 5'd20);
        total++;
        if (rv1 !== 32'h0A)
            $display("FAIL wr_rd1 got %h expected 0000000a", rv1);
        else
            passed++;
        total++;
        if (rv2 !== 32'h2)
            $display("FAIL wr_rd2 got %h expected 00000002", rv2);
        else
            passed++;
        do_read(5'd4, 5'd4);
        total++;
        if (rv1 !== 32'h12 || rv2 !== 32'h12)
            $display("FAIL same_addr got %h/%h expected 12/12", rv1, rv2);
        else
            passed++;
    endtask

    task automatic test_x0();
        do_write(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd0);
        total++;
        if (rv1 !== 32'h0 || rv2 !== 32'h0)
            $display("FAIL x0_zero got %h/%h expected 0/0", rv1, rv2);
        else
            passed++;
    endtask

    task automatic test_hold();
        do_read(5'd5, 5'd20);
        ra1 = 5'd5;
        ra2 = 5'd5;
        do_write(5'd5, 32'h77);
        total++;
        if (rv1 !== 32'h0A || rv2 !== 32'h2)
            $display("FAIL hold_wr got %h/%h expected a/2", rv1, rv2);
        else
            passed++;
        do_write(5'd6, 32'h55);
        total++;
        if (rv1 !== 32'h0A || rv2 !== 32'h2)
            $display("FAIL hold_wr2 got %h/%h expected a/2", rv1, rv2);
        else
            passed++;
        do_read(5'd5, 5'd6);
        total++;
        if (rv1 !== 32'h77 || rv2 !== 32'h55)
            $display("FAIL hold_rd got %h/%h expected 77/55", rv1, rv2);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        do_write(5'd7, 32'hDEAD_BEEF);
        do_write(5'd7, 32'h1);
        do_read(5'd7, 5'd7);
        total++;
        if (rv1 !== 32'h1 || rv2 !== 32'h1)
            $display("FAIL last_wins got %h/%h expected 1/1", rv1, rv2);
        else
            passed++;
        reset  = 1'b1;
        r_or_w = 1'b1;
        ra1    = 5'd7;
        ra2    = 5'd4;
        tick();
        total++;
        if (rv1 !== 32'h0 || rv2 !== 32'h0)
            $display("FAIL mid_reset got %h/%h expected 0/0", rv1, rv2);
        else
            passed++;
        do_read(5'd7, 5'd4);
        total++;
        if (rv1 !== 32'h0 || rv2 !== 32'h0)
            $display("FAIL post_reset got %h/%h expected 0/0", rv1, rv2);
        else
            passed++;
    endtask

    task automatic test_all_regs();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 1; i < 32; i++) begin
            do_read(5'(i), 5'(32 - i));
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(32 - i) * 32'h0101_0101;
            total++;
            if (rv1 !== e1 || rv2 !== e2)
                $display("FAIL all_regs[%0d] got %h/%h expected %h/%h",
                         i, rv1, rv2, e1, e2);
            else
                passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        r_or_w = 1'b1;
        ra1    = 5'd0;
        ra2    = 5'd0;
        wa     = 5'd0;
        wval   = 32'h0;
        test_reset();
        test_write_read();
        test_x0();
        test_hold();
        test_back_to_back();
        test_all_regs();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
